// File: rtl/store_rmw_if.sv
// Store request / data-memory bundle for store_rmw_ctrl.
// Signal suffixes follow the controller's point of view.
// STORE_RMW_NATIVE_BE_EN adds the mem_be_o byte-enable lane.
interface store_rmw_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [31:0]           req_addr_i;
  logic [31:0]           req_data_i;
  logic [2:0]            req_funct3_i;
  logic                  done_o;
  logic                  err_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_re_o;
  logic [31:0]           mem_rdata_i;
  logic                  mem_we_o;
  logic [31:0]           mem_wdata_o;
`ifdef STORE_RMW_NATIVE_BE_EN
  logic [3:0]            mem_be_o;
`endif

  // Controller side
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_funct3_i, mem_rdata_i,
    output req_ready_o, done_o, err_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
`ifdef STORE_RMW_NATIVE_BE_EN
    , output mem_be_o
`endif
  );

  // Store issue logic / memory side
  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_funct3_i, mem_rdata_i,
    input  req_ready_o, done_o, err_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
`ifdef STORE_RMW_NATIVE_BE_EN
    , input mem_be_o
`endif
  );
endinterface

// File: rtl/store_rmw_ctrl.sv
// Store controller: SB/SH/SW into a word-wide memory without byte enables.
// SW writes directly; SB/SH read the word, merge the lane(s), write it back.
// Misaligned or illegal requests pulse err_o and leave memory untouched.
// Define STORE_RMW_NATIVE_BE_EN for a memory with byte enables: every legal
// store then completes in one write cycle with mem_be_o selecting lanes.
module store_rmw_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  store_rmw_if.slave bus
);
  localparam logic [2:0] F3_SB     = 3'b000;
  localparam logic [2:0] F3_SH     = 3'b001;
  localparam logic [2:0] F3_SW     = 3'b010;
  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [1:0]            off_q, off_d;
  logic                  half_q, half_d;
  logic [15:0]           data_q, data_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            cnt_q, cnt_d;
`ifdef STORE_RMW_NATIVE_BE_EN
  logic [3:0]            be_q, be_d;
`endif

  logic [2:0] f3;
  logic [1:0] boff;
  logic       req_bad;
  logic       unused_addr_bits;

  assign f3               = bus.req_funct3_i;
  assign boff             = bus.req_addr_i[1:0];
  assign unused_addr_bits = ^bus.req_addr_i[31:ADDR_WIDTH+2];
  assign req_bad = !((f3 == F3_SB) ||
                     (f3 == F3_SH && !boff[0]) ||
                     (f3 == F3_SW && boff == 2'b00));

  // Replace the addressed byte or halfword of the read word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] d,
                                        input logic is_half, input logic [1:0] off);
    logic [31:0] w;
    w = old;
    if (is_half) begin
      if (off[1]) w[31:16] = d;
      else        w[15:0]  = d;
    end else begin
      unique case (off)
        2'd0: w[7:0]   = d[7:0];
        2'd1: w[15:8]  = d[7:0];
        2'd2: w[23:16] = d[7:0];
        2'd3: w[31:24] = d[7:0];
      endcase
    end
    return w;
  endfunction

  // State and request registers; reset abandons any pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      half_q  <= 1'b0;
      data_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
`ifdef STORE_RMW_NATIVE_BE_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      half_q  <= half_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
`ifdef STORE_RMW_NATIVE_BE_EN
      be_q    <= be_d;
`endif
    end
  end

  // Next-state logic: accept, read, wait for data and merge, write.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    half_d  = half_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
`ifdef STORE_RMW_NATIVE_BE_EN
    be_d    = be_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          waddr_d = bus.req_addr_i[ADDR_WIDTH+1:2];
          off_d   = boff;
          half_d  = (f3 == F3_SH);
          data_d  = bus.req_data_i[15:0];
          wdata_d = bus.req_data_i;
          if (req_bad) begin
            state_d = S_ERR;
`ifdef STORE_RMW_NATIVE_BE_EN
          end else begin
            state_d = S_WRITE;
            if (f3 == F3_SB) begin
              wdata_d = {4{bus.req_data_i[7:0]}};
              be_d    = 4'b0001 << boff;
            end else if (f3 == F3_SH) begin
              wdata_d = {2{bus.req_data_i[15:0]}};
              be_d    = boff[1] ? 4'b1100 : 4'b0011;
            end else begin
              be_d    = 4'b1111;
            end
          end
`else
          end else if (f3 == F3_SW) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
`endif
        end
      end
      S_READ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          wdata_d = merge(bus.mem_rdata_i, data_q, half_q, off_q);
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and handshake decoded from the current state.
  always_comb begin
    bus.req_ready_o = (state_q == S_IDLE);
    bus.mem_re_o    = (state_q == S_READ);
    bus.mem_we_o    = (state_q == S_WRITE);
    bus.done_o      = (state_q == S_WRITE);
    bus.err_o       = (state_q == S_ERR);
  end

  assign bus.mem_addr_o  = waddr_q;
  assign bus.mem_wdata_o = wdata_q;
`ifdef STORE_RMW_NATIVE_BE_EN
  assign bus.mem_be_o    = (state_q == S_WRITE) ? be_q : 4'b0000;
`endif
endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl with a simple fixed-latency memory model.
module tb_store_rmw_ctrl;
  localparam int unsigned AW = 12;
  localparam int unsigned RL = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_rmw_if #(.ADDR_WIDTH(AW)) bus ();

  store_rmw_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Read-only memory: data presented exactly RL cycles after mem_re_o.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [RL:1]   rd_vld;
  logic [AW-1:0] rd_addr [1:RL];
  always @(posedge clk) begin
    rd_vld[1]  <= bus.mem_re_o;
    rd_addr[1] <= bus.mem_addr_o;
    for (int i = 2; i <= RL; i++) begin
      rd_vld[i]  <= rd_vld[i-1];
      rd_addr[i] <= rd_addr[i-1];
    end
  end
  assign bus.mem_rdata_i = (rd_vld[RL] === 1'b1) ? mem[rd_addr[RL]] : 32'hBAAD_F00D;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in cycle N (checking ready), return in cycle N+1.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    chk({tag, "_ready_N"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = a;
    bus.req_data_i   = d;
    bus.req_funct3_i = f3;
    step();
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = 32'hFFFF_FFFF;
    bus.req_data_i   = 32'h0;
    bus.req_funct3_i = 3'b111;
    chk({tag, "_ready_N1"}, 32'(bus.req_ready_o), 32'd0);
  endtask

  task automatic after_done(input string tag);
    step();
    chk({tag, "_done_clr"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_we_clr"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.req_ready_o), 32'd1);
  endtask

  task automatic run_sw(input string tag, input logic [31:0] a, input logic [31:0] d);
    issue(tag, a, d, 3'b010);
    chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd1);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_re"}, 32'(bus.mem_re_o), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'(a[AW+1:2]));
    chk({tag, "_wdata"}, bus.mem_wdata_o, d);
`ifdef STORE_RMW_NATIVE_BE_EN
    chk({tag, "_be"}, 32'(bus.mem_be_o), 32'hF);
`endif
    after_done(tag);
  endtask

  task automatic run_sub(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input logic [31:0] exp_rmw,
                         input logic [31:0] exp_nat, input logic [3:0] exp_be);
    issue(tag, a, d, f3);
`ifdef STORE_RMW_NATIVE_BE_EN
    chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd1);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_re"}, 32'(bus.mem_re_o), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'(a[AW+1:2]));
    chk({tag, "_wdata"}, bus.mem_wdata_o, exp_nat);
    chk({tag, "_be"}, 32'(bus.mem_be_o), 32'(exp_be));
`else
    chk({tag, "_re"}, 32'(bus.mem_re_o), 32'd1);
    chk({tag, "_we_rd"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_raddr"}, 32'(bus.mem_addr_o), 32'(a[AW+1:2]));
    step();
    chk({tag, "_re_once"}, 32'(bus.mem_re_o), 32'd0);
    chk({tag, "_we_wait"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_done_wait"}, 32'(bus.done_o), 32'd0);
    repeat (RL) step();
    chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd1);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_re_wr"}, 32'(bus.mem_re_o), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.mem_addr_o), 32'(a[AW+1:2]));
    chk({tag, "_wdata"}, bus.mem_wdata_o, exp_rmw);
`endif
    after_done(tag);
  endtask

  task automatic run_err(input string tag, input logic [31:0] a, input logic [2:0] f3);
    issue(tag, a, 32'h1234_5678, f3);
    chk({tag, "_err"}, 32'(bus.err_o), 32'd1);
    chk({tag, "_re"}, 32'(bus.mem_re_o), 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    step();
    chk({tag, "_err_clr"}, 32'(bus.err_o), 32'd0);
    chk({tag, "_re2"}, 32'(bus.mem_re_o), 32'd0);
    chk({tag, "_we2"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
    chk({tag, "_re"}, 32'(bus.mem_re_o), 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[4] = 32'h1122_3344;
    mem[8] = 32'h1122_3344;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = 32'h0;
    bus.req_data_i   = 32'h0;
    bus.req_funct3_i = 3'b000;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_reset_state("rst");

    run_sw ("sw10", 32'h0000_0010, 32'hDEAD_BEEF);
    run_sub("sb13", 32'h0000_0013, 32'h0000_00AB, 3'b000, 32'hAB22_3344, 32'hABAB_ABAB, 4'b1000);
    run_sub("sb10", 32'h0000_0010, 32'h1234_56CD, 3'b000, 32'h1122_33CD, 32'hCDCD_CDCD, 4'b0001);
    run_sub("sb21", 32'h0000_0021, 32'hFFFF_FF77, 3'b000, 32'h1122_7744, 32'h7777_7777, 4'b0010);
    run_sub("sh22", 32'h0000_0022, 32'hFFFF_5A5A, 3'b001, 32'h5A5A_3344, 32'h5A5A_5A5A, 4'b1100);
    run_sub("sh20", 32'h0000_0020, 32'hFFFF_5A5A, 3'b001, 32'h1122_5A5A, 32'h5A5A_5A5A, 4'b0011);

    run_err("err_sh21", 32'h0000_0021, 3'b001);
    run_err("err_sw06", 32'h0000_0006, 3'b010);
    run_err("err_f3_3", 32'h0000_0010, 3'b011);
    run_err("err_f3_7", 32'h0000_0010, 3'b111);

`ifndef STORE_RMW_NATIVE_BE_EN
    // Reset while waiting for read data: the write must be abandoned.
    issue("rstmid", 32'h0000_0013, 32'h0000_00AB, 3'b000);
    chk("rstmid_re", 32'(bus.mem_re_o), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rstmid_after");
    step();
    chk("rstmid_no_we", 32'(bus.mem_we_o), 32'd0);
    chk("rstmid_no_done", 32'(bus.done_o), 32'd0);
`endif
    run_sw("sw_post", 32'h0000_0040, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
- Store-side counterpart of the load data path; executes SB / SH / SW into a word-wide data memory that has no byte enables.
- Full-word stores are written directly. Byte and halfword stores use a read-modify-write: read the word, merge the lane(s), write back.
- Sits between the processor's store issue logic and the data memory port.
- Flags misaligned or illegal store requests without touching memory.

Parameters:
- ADDR_WIDTH, 12, width of the word address driven to memory (byte address bits [ADDR_WIDTH+1:2]).
- READ_LATENCY, 1, cycles from mem_re_o asserted to mem_rdata_i valid; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous and active-high.
- req_valid_i  in  1  store request valid.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  32  byte address.
- req_data_i  in  32  store data (rs2).
- req_funct3_i  in  3  000 SB, 001 SH, 010 SW; all other values are illegal.
- done_o  out  1  one-cycle pulse: store committed.
- err_o  out  1  one-cycle pulse: misaligned or illegal request, memory untouched.
- mem_addr_o  out  ADDR_WIDTH  word address.
- mem_re_o  out  1  memory read strobe.
- mem_rdata_i  in  32  memory read data.
- mem_we_o  out  1  memory write strobe.
- mem_wdata_o  out  32  memory write data.

Behaviour:
- Reset: state IDLE; req_ready_o=1; done_o, err_o, mem_re_o, mem_we_o = 0; mem_addr_o and mem_wdata_o = 0.
- Reset asserted mid-operation: return to IDLE on the next edge. A write not yet strobed is abandoned; memory is unchanged.
- Handshake:
  - req_ready_o=1 only in IDLE.
  - A request is accepted on a cycle where req_valid_i & req_ready_o are both high.
  - addr, data and funct3 are latched on acceptance.
  - req_ready_o drops the cycle after acceptance and returns to 1 the cycle after done_o or err_o.
- Error check at acceptance:
  - SH with addr[0]=1, SW with addr[1:0]!=0, or an illegal funct3 -> ERR.
- FSM states:
  - IDLE: accept a request. Go to ERR if the error check fails, WRITE if SW, otherwise READ.
  - READ: mem_re_o=1 for exactly one cycle; mem_addr_o=addr[ADDR_WIDTH+1:2]; go to WAIT.
  - WAIT: count READ_LATENCY cycles. In the final WAIT cycle, sample mem_rdata_i, merge into a registered word, and go to WRITE.
  - WRITE: mem_we_o=1 for exactly one cycle; mem_wdata_o = merged word (or req_data for SW); done_o=1 in the same cycle; go to IDLE.
  - ERR: err_o=1 for one cycle, no memory strobes; go to IDLE.
- Merge rules:
  - SB, offset k: byte k replaced by data[7:0]; all other bytes are kept from the read word.
  - SH, offset 0: bits [15:0] replaced by data[15:0].
  - SH, offset 2: bits [31:16] replaced by data[15:0].
  - Upper bits of req_data_i beyond the stored width are ignored.
- Latency, with acceptance at cycle N:
  - SW: write/done at N+1.
  - SB/SH: read at N+1, write/done at N+2+READ_LATENCY.
  - Error: err_o at N+1.
- mem_re_o and mem_we_o are never high in the same cycle.
- mem_addr_o holds its value through READ, WAIT and WRITE.
- Back-to-back requests: a new request is accepted no earlier than the cycle after done_o; no pipelining.

Optional Feature:
- Macro: STORE_RMW_NATIVE_BE_EN.
- When defined:
  - Adds port mem_be_o (out, 4).
  - All legal stores take the SW path and complete in one cycle: write/done at N+1; READ/WAIT are never entered.
  - mem_wdata_o = data replicated into the addressed lanes (byte replicated ×4, halfword ×2).
  - mem_be_o: SB=0001<<k, SH=0011 or 1100, SW=1111; mem_be_o is 0 when mem_we_o=0.
  - Error handling is unchanged.
- When undefined: no mem_be_o port; read-modify-write behaviour as above.

Test Plan:
- SW addr=0x0000_0010, data=0xDEAD_BEEF -> at N+1: mem_we_o=1, mem_addr_o=4, mem_wdata_o=0xDEADBEEF, done_o=1; mem_re_o never asserted.
- SB addr=0x13, data=0x0000_00AB, memory word 0x11223344, READ_LATENCY=1 -> mem_re_o at N+1, write at N+3 with 0xAB223344, done_o at N+3.
- SH addr=0x22, data=0xFFFF_5A5A, memory 0x11223344 -> write 0x5A5A3344; SH addr=0x20 with the same data -> 0x11225A5A.
- SH addr=0x21, SW addr=0x06, and funct3=011 -> err_o pulse at N+1 for each; no mem_re_o/mem_we_o; req_ready_o=1 at N+2.
- SB accepted, rst_i asserted during WAIT -> no mem_we_o, all outputs 0 and req_ready_o=1 after the reset edge; a following SW completes normally.
- With STORE_RMW_NATIVE_BE_EN defined, SB addr=0x13, data=0xAB -> at N+1: mem_be_o=1000, mem_wdata_o=0xABABABAB, done_o=1.
